// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nn_pkg
//  Description : Shared definitions for the neuron datapath: default widths,
//                the accumulator FSM state encoding and Q-format constants.
//  Revision    : 1.0  initial release
// ============================================================================
package nn_pkg;

    // Default operand geometry: Q16.16 signed operands, 32-bit neuron index.
    localparam int DEF_DATA_W = 32;
    localparam int DEF_FRAC_W = 16;
    localparam int DEF_ID_W   = 32;
    localparam int DEF_N_IN   = 4;

    // Accumulator FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RND  = 2'd2,
        OUT  = 2'd3
    } nn_state_t;

    // Q-format constants for the default operand format.
    localparam logic [DEF_DATA_W-1:0] ONE      = DEF_DATA_W'(1) << DEF_FRAC_W;
    localparam logic [DEF_DATA_W-1:0] HALF_LSB = DEF_DATA_W'(1) << (DEF_FRAC_W - 1);
    localparam logic [DEF_DATA_W-1:0] SAT_MAX  = {1'b0, {(DEF_DATA_W-1){1'b1}}};
    localparam logic [DEF_DATA_W-1:0] SAT_MIN  = {1'b1, {(DEF_DATA_W-1){1'b0}}};

    // Accumulator width that cannot overflow for up to 1024 full-scale
    // products plus the aligned bias: 2*DATA_W product bits + 10 growth bits
    // + 1 bit of headroom for the bias term.
    function automatic int acc_width(input int data_w);
        return 2 * data_w + 11;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fx_round_sat.sv
`default_nettype none
// ============================================================================
//  Module      : fx_round_sat
//  Description : Combinational fixed-point narrowing. Takes a wide signed
//                value carrying FRAC_W extra fraction bits, rounds half-up
//                (toward +inf) and saturates to a signed OUT_W result.
//  Revision    : 1.0  initial release
// ============================================================================
module fx_round_sat
    import nn_pkg::*;
#(
    parameter int IN_W   = 75,
    parameter int OUT_W  = 32,
    parameter int FRAC_W = 16
) (
    input  logic [IN_W-1:0]  acc_in,
    output logic [OUT_W-1:0] val,
    output logic             sat
);

    // One extra bit so adding the rounding constant can never wrap.
    localparam int EXT_W = IN_W + 1;
    localparam logic [EXT_W-1:0] c_round_half = EXT_W'(1) << (FRAC_W - 1);
    localparam logic [OUT_W-1:0] c_sat_max    = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] c_sat_min    = {1'b1, {(OUT_W-1){1'b0}}};

    logic [EXT_W-1:0]           w_ext;
    logic [EXT_W-1:0]           w_sum;
    logic signed [EXT_W-1:0]    w_shift;
    logic [EXT_W-OUT_W:0]       w_top;
    logic                       w_pos_ovf;
    logic                       w_neg_ovf;

    assign w_ext   = {acc_in[IN_W-1], acc_in};
    assign w_sum   = w_ext + c_round_half;
    assign w_shift = $signed(w_sum) >>> FRAC_W;

    // The result fits only if every bit from the output sign bit upward is a
    // copy of the sign; otherwise the sign decides which rail to clip to.
    assign w_top     = w_shift[EXT_W-1:OUT_W-1];
    assign w_pos_ovf = !w_shift[EXT_W-1] && (|w_top);
    assign w_neg_ovf =  w_shift[EXT_W-1] && !(&w_top);

    // Select the clipped rail or the in-range rounded value.
    always_comb begin
        val = w_shift[OUT_W-1:0];
        sat = 1'b0;
        if (w_pos_ovf) begin
            val = c_sat_max;
            sat = 1'b1;
        end else if (w_neg_ovf) begin
            val = c_sat_min;
            sat = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/neuron_accum.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_accum
//  Description : Per-neuron weighted sum. Takes a bias on start, accumulates
//                N_IN (x, w) products at full precision, then rounds and
//                saturates to the operand Q-format and offers the result,
//                tagged with the neuron index, on a valid/ready port.
//  Revision    : 1.0  initial release
// ============================================================================
module neuron_accum
    import nn_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int N_IN   = DEF_N_IN,
    parameter int ID_W   = DEF_ID_W,
    parameter int ACC_W  = acc_width(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] bias,
    input  logic [ID_W-1:0]   n_id,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] w,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] act_out,
    output logic [ID_W-1:0]   n_idx,
    output logic              sat,
    output logic              busy
);

    // Counter is sized for the value N_IN so that N_IN = 1 still gets a bit.
    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = $clog2(N_IN + 1);
    localparam logic [CNT_W-1:0] c_last_beat = CNT_W'(N_IN - 1);

    nn_state_t          r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [ID_W-1:0]    r_id_lat;
    logic [DATA_W-1:0]  r_act;
    logic [ID_W-1:0]    r_idx;
    logic               r_sat;
    logic               r_out_valid;

    logic [PROD_W-1:0]  w_x_ext;
    logic [PROD_W-1:0]  w_w_ext;
    logic [PROD_W-1:0]  w_prod;
    logic [ACC_W-1:0]   w_prod_ext;
    logic [ACC_W-1:0]   w_bias_ext;
    logic [DATA_W-1:0]  w_rs_val;
    logic               w_rs_sat;

    // Full 2*DATA_W signed product: both operands are sign-extended to the
    // product width so the multiply is exact in two's complement.
    assign w_x_ext    = {{DATA_W{x[DATA_W-1]}}, x};
    assign w_w_ext    = {{DATA_W{w[DATA_W-1]}}, w};
    assign w_prod     = $signed(w_x_ext) * $signed(w_w_ext);
    assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};

    // Bias is aligned to the product scale (2*FRAC_W fraction bits).
    assign w_bias_ext = {{(ACC_W-DATA_W-FRAC_W){bias[DATA_W-1]}}, bias, {FRAC_W{1'b0}}};

    fx_round_sat #(
        .IN_W   (ACC_W),
        .OUT_W  (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_round_sat (
        .acc_in (r_acc),
        .val    (w_rs_val),
        .sat    (w_rs_sat)
    );

    // Sequencer: bias load, beat accumulation, one rounding cycle, result hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_id_lat    <= '0;
            r_act       <= '0;
            r_idx       <= '0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc    <= w_bias_ext;
                        r_id_lat <= n_id;
                        r_cnt    <= '0;
                        r_state  <= ACC;
                    end
                end
                ACC: begin
                    // in_ready is high for the whole state, so in_valid
                    // alone marks an accepted beat.
                    if (in_valid) begin
                        r_acc <= r_acc + w_prod_ext;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == c_last_beat) begin
                            r_state <= RND;
                        end
                    end
                end
                RND: begin
                    r_act       <= w_rs_val;
                    r_sat       <= w_rs_sat;
                    r_idx       <= r_id_lat;
                    r_out_valid <= 1'b1;
                    r_state     <= OUT;
                end
                OUT: begin
                    // Result stays put until taken; act_out then keeps its
                    // value until the next rounding cycle overwrites it.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ACC);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign act_out   = r_act;
    assign n_idx     = r_idx;
    assign sat       = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_neuron_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_neuron_accum
//  Description : Self-checking bench for neuron_accum (Q16.16, N_IN = 4).
//                Expected results are queued when a neuron is launched and
//                compared when the output handshake completes.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_neuron_accum;

    localparam int DATA_W = 32;
    localparam int FRAC_W = 16;
    localparam int N_IN   = 4;
    localparam int ID_W   = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] bias = '0;
    logic [31:0] n_id = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] x = '0;
    logic [31:0] w = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] act_out;
    logic [31:0] n_idx;
    logic        sat;
    logic        busy;

    always #5 clk = ~clk;

    neuron_accum #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .N_IN   (N_IN),
        .ID_W   (ID_W),
        .ACC_W  (2*DATA_W+11)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bias      (bias),
        .n_id      (n_id),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .w         (w),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .act_out   (act_out),
        .n_idx     (n_idx),
        .sat       (sat),
        .busy      (busy)
    );

    typedef struct packed {
        logic [31:0] act;
        logic        sat;
        logic [31:0] idx;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   n_push = 0;
    int   n_out  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: exact wide sum, round half-up, clip to 32-bit signed.
    function automatic exp_t model(input logic [31:0] b, input logic [31:0] id,
                                   input logic [31:0] xs[4], input logic [31:0] ws[4]);
        logic signed [74:0] acc;
        logic signed [74:0] r;
        longint             p;
        exp_t               e;
        acc = 75'(longint'($signed(b))) * 75'sd65536;
        for (int k = 0; k < 4; k++) begin
            p   = longint'($signed(xs[k])) * longint'($signed(ws[k]));
            acc = acc + 75'(p);
        end
        r = (acc + 75'sd32768) >>> 16;
        e.idx = id;
        if (r > 75'sd2147483647) begin
            e.act = 32'h7FFFFFFF;
            e.sat = 1'b1;
        end else if (r < -75'sd2147483648) begin
            e.act = 32'h80000000;
            e.sat = 1'b1;
        end else begin
            e.act = r[31:0];
            e.sat = 1'b0;
        end
        return e;
    endfunction

    // Scoreboard consumer: compare whenever the output handshake will fire.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check("act_out", act_out, e.act);
                check("sat", 32'(sat), 32'(e.sat));
                check("n_idx", n_idx, e.idx);
                n_out++;
            end
        end
    end

    // Launch one neuron and follow it through to the output handshake.
    task automatic run_neuron(input logic [31:0] b, input logic [31:0] id,
                              input logic [31:0] xs[4], input logic [31:0] ws[4],
                              input bit stall, input bit inj,
                              input logic [31:0] ea, input bit es);
        exp_t        e;
        int          guard;
        int          i;
        int          cyc;
        logic        rdy;
        logic [6:0]  pat;
        pat   = 7'b1011001;   // bit k = in_valid in beat cycle k: 1,0,0,1,1,0,1
        e.act = ea;
        e.sat = es;
        e.idx = id;
        sb_q.push_back(e);
        n_push++;
        out_ready = !stall;

        guard = 0;
        @(negedge clk);
        while (busy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("idle_before_start", 32'(busy), 32'd0);
        check("in_ready_idle", 32'(in_ready), 32'd0);
        start = 1'b1;
        bias  = b;
        n_id  = id;
        @(posedge clk); #1;
        start = 1'b0;

        i   = 0;
        cyc = 0;
        while (i < N_IN) begin
            in_valid = stall ? pat[cyc % 7] : 1'b1;
            x = in_valid ? xs[i] : $urandom;
            w = in_valid ? ws[i] : $urandom;
            if (inj && cyc == 1) begin
                start = 1'b1;
                bias  = 32'h7FFF0000;
                n_id  = ~id;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            rdy = in_ready;
            check("in_ready_acc", 32'(rdy), 32'd1);
            @(posedge clk);
            if (in_valid && rdy) i++;
            #1;
            cyc++;
            if (cyc > 40) begin
                check("beat_timeout", 32'(i), 32'(N_IN));
                break;
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
        x        = $urandom;
        w        = $urandom;

        // One edge after the last beat: rounding cycle, nothing offered yet.
        @(negedge clk);
        check("ov_early", 32'(out_valid), 32'd0);
        check("in_ready_rnd", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        if (inj) begin
            start = 1'b1;
            bias  = 32'h7FFF0000;
            n_id  = ~id;
        end
        @(negedge clk);
        check("ov_rise", 32'(out_valid), 32'd1);
        if (stall) begin
            repeat (5) begin
                @(posedge clk); #1;
                start = 1'b0;
                @(negedge clk);
                check("stall_ov", 32'(out_valid), 32'd1);
                check("stall_act", act_out, ea);
                check("stall_idx", n_idx, id);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("ov_drop", 32'(out_valid), 32'd0);
        check("idle_after", 32'(busy), 32'd0);
        check("act_hold", act_out, ea);
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] xs[4];
        logic [31:0] ws[4];
        logic [31:0] b;
        exp_t        e;

        // Reset state.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_act_out", act_out, 32'd0);
        check("rst_n_idx", n_idx, 32'd0);
        check("rst_sat", 32'(sat), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic sum: 0.25 + 0.5*(1 + 2 - 0.5 + 0.25) = 1.625.
        xs = '{32'h00010000, 32'h00020000, 32'hFFFF8000, 32'h00004000};
        ws = '{32'h00008000, 32'h00008000, 32'h00008000, 32'h00008000};
        run_neuron(32'h00004000, 32'h00000011, xs, ws, 1'b0, 1'b0, 32'h0001A000, 1'b0);

        // Rounding: +0.5 LSB rounds up, -0.5 LSB rounds up to zero.
        xs = '{32'h00000001, 32'h0, 32'h0, 32'h0};
        ws = '{32'h00008000, 32'h0, 32'h0, 32'h0};
        run_neuron(32'h0, 32'h00000021, xs, ws, 1'b0, 1'b0, 32'h00000001, 1'b0);
        xs[0] = 32'hFFFFFFFF;
        run_neuron(32'h0, 32'h00000022, xs, ws, 1'b0, 1'b0, 32'h00000000, 1'b0);

        // Saturation at both rails.
        xs = '{32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000};
        ws = '{32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000};
        run_neuron(32'h0, 32'h00000031, xs, ws, 1'b0, 1'b0, 32'h7FFFFFFF, 1'b1);
        xs = '{32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000};
        run_neuron(32'h0, 32'h00000032, xs, ws, 1'b0, 1'b0, 32'h80000000, 1'b1);

        // Reset after two beats of a neuron; its partial sum must vanish.
        start = 1'b1;
        bias  = 32'h00050000;
        n_id  = 32'h00000099;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        x        = 32'h00030000;
        w        = 32'h00030000;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_act_out", act_out, 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        xs = '{32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000};
        ws = '{32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000};
        run_neuron(32'h0, 32'h00000035, xs, ws, 1'b0, 1'b0, 32'h00040000, 1'b0);

        // Input stalls and output back-pressure give the unstalled result.
        xs = '{32'h00010000, 32'h00020000, 32'hFFFF8000, 32'h00004000};
        ws = '{32'h00008000, 32'h00008000, 32'h00008000, 32'h00008000};
        run_neuron(32'h00004000, 32'h00000041, xs, ws, 1'b1, 1'b0, 32'h0001A000, 1'b0);

        // Start pulses during ACC and OUT are ignored.
        run_neuron(32'h00004000, 32'h00000051, xs, ws, 1'b0, 1'b1, 32'h0001A000, 1'b0);
        run_neuron(32'h00004000, 32'h00000052, xs, ws, 1'b1, 1'b1, 32'h0001A000, 1'b0);

        // Random neurons checked against the reference model.
        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j < 4; j++) begin
                xs[j] = $urandom;
                ws[j] = $urandom;
                if (k < 4) begin
                    xs[j] = 32'($signed(xs[j]) >>> 12);
                    ws[j] = 32'($signed(ws[j]) >>> 12);
                end
            end
            b = $urandom;
            if (k < 4) b = 32'($signed(b) >>> 8);
            e = model(b, 32'h00000100 + 32'(k), xs, ws);
            run_neuron(b, 32'h00000100 + 32'(k), xs, ws, k[0], k[1], e.act, e.sat);
        end

        repeat (3) @(posedge clk);
        check("sb_left", 32'(sb_q.size()), 32'd0);
        check("n_out", 32'(n_out), 32'(n_push));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
